// File: rtl/mvau_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvau_defn (package)
// Description : Shared types and parameter derivations for the MVAU
//               stream controller and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package mvau_defn;

  // Fold-loop phase: FILL takes words from the stream, REUSE replays the buffer
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    REUSE = 1'b1
  } mvau_ctrl_state_t;

  localparam int DEF_SF       = 4;
  localparam int DEF_NF       = 2;
  localparam int DEF_PIPE_LAT = 2;

  // Counter width for a modulo-n counter; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when n is a non-zero power of two
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  localparam int DEF_SF_T = cnt_width(DEF_SF);
  localparam int DEF_NF_T = cnt_width(DEF_NF);

endpackage
`default_nettype wire

// File: rtl/mvau_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mvau_stream_ctrl_if
// Description : Handshake and datapath-control bundle of the MVAU stream
//               controller. master = controller, slave = stream/datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mvau_stream_ctrl_if #(
  parameter int SF_T = 2,
  parameter int NF_T = 1
);
  logic                 in_v;
  logic                 in_rdy;
  logic                 out_rdy;
  logic                 out_v;
  logic                 pipe_en;
  logic                 acc_en;
  logic                 sf_clr;
  logic                 ib_wen;
  logic                 ib_ren;
  logic [SF_T-1:0]      sf_cnt;
  logic [NF_T-1:0]      nf_cnt;
  logic [SF_T+NF_T-1:0] wgt_addr;

  modport master (
    input  in_v, out_rdy,
    output in_rdy, out_v, pipe_en, acc_en, sf_clr, ib_wen, ib_ren,
           sf_cnt, nf_cnt, wgt_addr
  );

  modport slave (
    output in_v, out_rdy,
    input  in_rdy, out_v, pipe_en, acc_en, sf_clr, ib_wen, ib_ren,
           sf_cnt, nf_cnt, wgt_addr
  );
endinterface
`default_nettype wire

// File: rtl/mvau_stream_ctrl_vld_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mvau_vld_pipe
// Description : DEPTH-deep enabled shift register carrying valid tokens
//               alongside a stall-able compute pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mvau_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic din,
  output logic      dout
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: capture the token whenever the pipeline advances
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else if (en) begin
          r_sr <= din;
        end
      end
    end else begin : g_chain
      // Multi stage: shift toward the output whenever the pipeline advances
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sr <= '0;
        end else if (en) begin
          r_sr <= {r_sr[DEPTH-2:0], din};
        end
      end
    end
  endgenerate

  assign dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mvau_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mvau_stream_ctrl
// Description : Stall-aware SF x NF fold sequencer for the MVAU datapath.
//               Accepts activations on a valid/ready stream, drives the
//               input buffer and weight address, and tags output validity.
// Revision    : 1.0 - initial release
// ============================================================================
module mvau_stream_ctrl
  import mvau_defn::*;
#(
  parameter int SF       = DEF_SF,
  parameter int NF       = DEF_NF,
  parameter int SF_T     = cnt_width(SF),
  parameter int NF_T     = cnt_width(NF),
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mvau_stream_ctrl_if.master bus
);

  localparam int AW = SF_T + NF_T;

  localparam logic [0:0]      ST_FILL  = FILL;
  localparam logic [0:0]      ST_REUSE = REUSE;
  localparam logic [SF_T-1:0] SF_LAST  = SF_T'(SF - 1);
  localparam logic [NF_T-1:0] NF_LAST  = NF_T'(NF - 1);

  logic [0:0]      r_state;
  logic [SF_T-1:0] r_sf;
  logic [NF_T-1:0] r_nf;

  logic w_out_v;
  logic w_stall;
  logic w_pipe_en;
  logic w_fill;
  logic w_step;
  logic w_sf_wrap;
  logic w_nf_wrap;
  logic w_clr;
  logic [AW-1:0] w_addr;

  // A held output freezes the whole datapath; reset also forces every
  // enable low so nothing downstream sees activity while rst is high.
  assign w_stall   = w_out_v & ~bus.out_rdy;
  assign w_pipe_en = ~rst & ~w_stall;
  assign w_fill    = (r_state == ST_FILL);
  assign w_step    = w_pipe_en & (w_fill ? bus.in_v : 1'b1);
  assign w_sf_wrap = (r_sf == SF_LAST);
  assign w_nf_wrap = (r_nf == NF_LAST);
  assign w_clr     = w_step & w_sf_wrap;

  // Fold counters and FILL/REUSE phase, advancing one fold step at a time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_sf    <= '0;
      r_nf    <= '0;
    end else if (w_step) begin
      if (w_sf_wrap) begin
        r_sf <= '0;
        r_nf <= w_nf_wrap ? '0 : r_nf + NF_T'(1);
        if (w_fill && (NF > 1)) begin
          r_state <= ST_REUSE;
        end else if (!w_fill && w_nf_wrap) begin
          r_state <= ST_FILL;
        end
      end else begin
        r_sf <= r_sf + SF_T'(1);
      end
    end
  end

  // Tile-major weight address: a plain concatenation only when SF is a
  // power of two that actually occupies the sf field bits.
  generate
    if (is_pow2(SF) && (SF > 1)) begin : g_addr_cat
      assign w_addr = {r_nf, r_sf};
    end else begin : g_addr_mad
      assign w_addr = AW'(r_nf) * AW'(SF) + AW'(r_sf);
    end
  endgenerate

  // The last fold step of a tile launches a result token down the pipe
  mvau_vld_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_vld_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (w_pipe_en),
    .din  (w_clr),
    .dout (w_out_v)
  );

  assign bus.in_rdy   = w_fill & w_pipe_en;
  assign bus.out_v    = w_out_v;
  assign bus.pipe_en  = w_pipe_en;
  assign bus.acc_en   = w_step;
  assign bus.sf_clr   = w_clr;
  assign bus.ib_wen   = w_step & w_fill;
  assign bus.ib_ren   = ~w_fill & w_pipe_en;
  assign bus.sf_cnt   = r_sf;
  assign bus.nf_cnt   = r_nf;
  assign bus.wgt_addr = w_addr;

endmodule
`default_nettype wire
